// File: rtl/rs_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// rs_dispatch_pkg
//   Shared definitions for the reservation-station dispatch router:
//   functional-unit class numbers, opcode constants, the packed payload
//   carried to each reservation station, and the class decode helpers.
//
//   Payload widths are fixed here. The router's DATA_W / PREG_W / INUM_W
//   parameters default to these values and must be left equal to them.
// ---------------------------------------------------------------------------
package rs_dispatch_pkg;

  // Functional-unit classes; classes above FU_DIV never receive entries.
  localparam int FU_ALU = 0;
  localparam int FU_MUL = 1;
  localparam int FU_DIV = 2;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  localparam int RS_DATA_W = 32;
  localparam int RS_PREG_W = 8;
  localparam int RS_INUM_W = 32;
  localparam int CTRL_W    = 11;

  // One reservation-station entry, MSB first.
  typedef struct packed {
    logic [RS_DATA_W-1:0] operand1;
    logic [RS_DATA_W-1:0] operand2;
    logic [RS_DATA_W-1:0] pc;
    logic [RS_DATA_W-1:0] immediate;
    logic [2:0]           func3;
    logic [CTRL_W-1:0]    ctrl;       // {MemToReg, MemRead, MemWrite, ALUOP[3:0], ALUSrc1, ALUSrc2, Jump, Branch}
    logic [RS_PREG_W-1:0] rd_phy;
    logic [RS_PREG_W-1:0] op1_phy;
    logic [RS_PREG_W-1:0] op2_phy;
    logic [1:0]           opvalid;
    logic [RS_INUM_W-1:0] inst_num;
    logic                 taken;
    logic                 hit;
  } payload_t;

  localparam int PAYLOAD_W = $bits(payload_t);

  typedef logic [1:0] fu_class_t;

  // M-extension R-type ops split on func3[2]: multiplies below, divides/remainders above.
  function automatic fu_class_t classify(input logic [6:0] opcode,
                                         input logic [6:0] funct7,
                                         input logic [2:0] func3);
    fu_class_t cls;
    cls = fu_class_t'(FU_ALU);
    if (opcode == OP_R && funct7 == F7_MULDIV)
      cls = func3[2] ? fu_class_t'(FU_DIV) : fu_class_t'(FU_MUL);
    return cls;
  endfunction

  // Only control-transfer instructions carry meaningful predictor state.
  function automatic logic keeps_prediction(input logic [6:0] opcode);
    return (opcode == OP_JAL) || (opcode == OP_JALR) || (opcode == OP_BR);
  endfunction

endpackage

// File: rtl/rs_dispatch_fifo.sv
// ---------------------------------------------------------------------------
// rs_dispatch_fifo
//   Single-class FIFO feeding one reservation station. Entries younger than
//   a flush boundary are killed in place; a killed head is drained silently
//   one per cycle while out_valid stays low.
//
//   Ports
//     clk, reset       clock, asynchronous active-low reset
//     push, push_data  write request (ignored when full) and entry
//     full             no free slot
//     flush_valid      kill entries with inst_num > flush_inst_num
//     flush_inst_num   flush boundary (unsigned compare)
//     out_valid        head is occupied and live
//     out_ready        consumer accepts the head
//     out_payload      head entry, zero when out_valid is low
//     count            occupied slots, dead or live
// ---------------------------------------------------------------------------
module rs_dispatch_fifo
  import rs_dispatch_pkg::*;
#(
  parameter int BUF_DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  payload_t                   push_data,
  output logic                       full,
  input  logic                       flush_valid,
  input  logic [RS_INUM_W-1:0]       flush_inst_num,
  output logic                       out_valid,
  input  logic                       out_ready,
  output payload_t                   out_payload,
  output logic [$clog2(BUF_DEPTH):0] count
);

  localparam int IDX_W = $clog2(BUF_DEPTH);

  payload_t             mem [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] alive;
  logic [BUF_DEPTH-1:0] alive_next;
  logic [BUF_DEPTH-1:0] kill;
  logic [IDX_W:0]       wr_ptr;
  logic [IDX_W:0]       rd_ptr;
  logic [IDX_W-1:0]     wr_idx;
  logic [IDX_W-1:0]     rd_idx;
  logic                 occupied;
  logic                 head_alive;
  logic                 pop;
  logic                 do_push;

  assign wr_idx = wr_ptr[IDX_W-1:0];
  assign rd_idx = rd_ptr[IDX_W-1:0];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count    = wr_ptr - rd_ptr;
  assign occupied = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[IDX_W] != rd_ptr[IDX_W]) && (wr_idx == rd_idx);

  assign head_alive = alive[rd_idx];
  assign out_valid  = occupied && head_alive;
  // A dead head leaves regardless of out_ready: it was never offered.
  assign pop        = occupied && (!head_alive || out_ready);
  assign do_push    = push && !full;

  // Gating keeps the bus quiet while nothing live is offered, so the
  // unreset storage never shows through.
  assign out_payload = out_valid ? mem[rd_idx] : '0;

  // NOTE: every variable assigned in always_comb gets a default first; a path
  // that skips an assignment would otherwise infer a latch.
  always_comb begin
    kill = '0;
    for (int i = 0; i < BUF_DEPTH; i++)
      kill[i] = flush_valid && (mem[i].inst_num > flush_inst_num);
  end

  // Push goes to a free slot, so it never collides with a killed or popped one.
  always_comb begin
    alive_next = alive & ~kill;
    if (pop)
      alive_next[rd_idx] = 1'b0;
    if (do_push)
      alive_next[wr_idx] = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      alive  <= '0;
    end else begin
      alive <= alive_next;
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: entry storage is not reset; the valid bits and pointers alone decide
  // what is visible, which keeps the array free of reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_idx] <= push_data;
  end

endmodule

// File: rtl/rs_dispatch_router.sv
// ---------------------------------------------------------------------------
// rs_dispatch_router
//   Registered dispatch stage between rename/decode and the ALU, MUL and DIV
//   reservation stations. Each decoded instruction is classified, stripped
//   of predictor bits unless it is a control transfer, and pushed into its
//   class FIFO. Bubbles (opcode 0) are accepted and dropped. A selective
//   flush kills stored entries and the same-cycle input younger than
//   flush_inst_num. Nothing on in_* reaches out_* combinationally.
//
//   Ports
//     clk, reset             clock, asynchronous active-low reset
//     in_valid / in_ready    input handshake
//     in_opcode, in_func3, in_funct7, in_operand1/2, in_pc, in_immediate,
//     in_ctrl, in_rd_phy, in_op1_phy, in_op2_phy, in_opvalid, in_inst_num,
//     in_taken, in_hit       decoded instruction fields
//     flush_valid, flush_inst_num   selective flush
//     out_valid / out_ready  per-class handshake to the reservation stations
//     out_payload            per-class head entry (payload_t slices)
//     out_count              per-class occupancy
// ---------------------------------------------------------------------------
module rs_dispatch_router
  import rs_dispatch_pkg::*;
#(
  parameter int NUM_FU    = 3,
  parameter int BUF_DEPTH = 4,
  parameter int DATA_W    = RS_DATA_W,
  parameter int PREG_W    = RS_PREG_W,
  parameter int INUM_W    = RS_INUM_W
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  input  logic [6:0]                                in_opcode,
  input  logic [2:0]                                in_func3,
  input  logic [6:0]                                in_funct7,
  input  logic [DATA_W-1:0]                         in_operand1,
  input  logic [DATA_W-1:0]                         in_operand2,
  input  logic [DATA_W-1:0]                         in_pc,
  input  logic [DATA_W-1:0]                         in_immediate,
  input  logic [CTRL_W-1:0]                         in_ctrl,
  input  logic [PREG_W-1:0]                         in_rd_phy,
  input  logic [PREG_W-1:0]                         in_op1_phy,
  input  logic [PREG_W-1:0]                         in_op2_phy,
  input  logic [1:0]                                in_opvalid,
  input  logic [INUM_W-1:0]                         in_inst_num,
  input  logic                                      in_taken,
  input  logic                                      in_hit,
  input  logic                                      flush_valid,
  input  logic [INUM_W-1:0]                         flush_inst_num,
  output logic [NUM_FU-1:0]                         out_valid,
  input  logic [NUM_FU-1:0]                         out_ready,
  output logic [NUM_FU*PAYLOAD_W-1:0]               out_payload,
  output logic [NUM_FU*($clog2(BUF_DEPTH)+1)-1:0]   out_count
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

  logic              is_bubble;
  logic              keep_pred;
  logic              flush_hit;
  fu_class_t         in_class;
  payload_t          in_entry;
  logic [NUM_FU-1:0] full;
  logic [NUM_FU-1:0] push;

  assign is_bubble = (in_opcode == OP_NOP);
  assign in_class  = classify(in_opcode, in_funct7, in_func3);
  assign keep_pred = keeps_prediction(in_opcode);

  // Readiness looks only at the target FIFO's current fullness; a pop in the
  // same cycle does not open a slot early.
  assign in_ready  = is_bubble || !full[in_class];

  // An input younger than a same-cycle flush is accepted but not stored.
  assign flush_hit = flush_valid && (in_inst_num > flush_inst_num);

  always_comb begin
    push = '0;
    if (in_valid && in_ready && !is_bubble && !flush_hit)
      push[in_class] = 1'b1;
  end

  always_comb begin
    in_entry           = '0;
    in_entry.operand1  = in_operand1;
    in_entry.operand2  = in_operand2;
    in_entry.pc        = in_pc;
    in_entry.immediate = in_immediate;
    in_entry.func3     = in_func3;
    in_entry.ctrl      = in_ctrl;
    in_entry.rd_phy    = in_rd_phy;
    in_entry.op1_phy   = in_op1_phy;
    in_entry.op2_phy   = in_op2_phy;
    in_entry.opvalid   = in_opvalid;
    in_entry.inst_num  = in_inst_num;
    in_entry.taken     = keep_pred && in_taken;
    in_entry.hit       = keep_pred && in_hit;
  end

  for (genvar c = 0; c < NUM_FU; c++) begin : g_fu
    if (c <= FU_DIV) begin : g_live
      payload_t         head;
      logic [CNT_W-1:0] cnt;

      rs_dispatch_fifo #(
        .BUF_DEPTH(BUF_DEPTH)
      ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .push          (push[c]),
        .push_data     (in_entry),
        .full          (full[c]),
        .flush_valid   (flush_valid),
        .flush_inst_num(flush_inst_num),
        .out_valid     (out_valid[c]),
        .out_ready     (out_ready[c]),
        .out_payload   (head),
        .count         (cnt)
      );

      assign out_payload[c*PAYLOAD_W +: PAYLOAD_W] = head;
      assign out_count[c*CNT_W +: CNT_W]           = cnt;
    end else begin : g_unused
      // No decode ever selects these classes; they stay permanently idle.
      assign full[c]                               = 1'b1;
      assign out_valid[c]                          = 1'b0;
      assign out_payload[c*PAYLOAD_W +: PAYLOAD_W] = '0;
      assign out_count[c*CNT_W +: CNT_W]           = '0;
    end
  end

endmodule
